coin_acceptor: RTL
==================

// Module: coin_acceptor
// PURPOSE
//  Front end of the vending path: conditions raw coin-slot sensors into the single-cycle
//  pulse + coin-code stream consumed by the vend FSM. Synchronises the two async sensor
//  lines, debounces them, accepts one coin per insertion and holds coin at NC between credits.
//  vend uses coin combinationally for sell/change, so coin is non-NC only when pulse is high.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser depth per sensor line; legal range >=2
//  DEB_CYCLES   16  consecutive stable FSM samples needed to accept an insert or a release;
//                   must be > SYNC_STAGES and >= 2
//  CNT_W        localparam = $clog2(DEB_CYCLES+1); width of the debounce counter
// PORTS
//  clk        in   1  system clock
//  rst_       in   1  reset; synchronous, active-low
//  coin05_raw in   1  async sensor, 0.5-yuan channel, high while a coin is in the slot
//  coin10_raw in   1  async sensor, 1-yuan channel, high while a coin is in the slot
//  pulse      out  1  one-cycle strobe; a coin was accepted this cycle
//  coin       out  2  coin_t: NC=00, Y05=01, Y1=10; non-NC only while pulse=1
//  reject     out  1  one-cycle strobe for an ambiguous insert (only with COIN_REJECT_EN)
// BEHAVIOUR
//  - Reset (rst_=0 at posedge): sync flops <=0, cnt<=0, state<=RELEASE, pulse=0, coin=NC,
//    reject=0. Reset mid-operation aborts any pending debounce. No credit is ever emitted
//    for a coin held in the slot across reset.
//  - All outputs are registered and driven from the current state only.
//  - pat = {sync10, sync05}, the synchronised sample seen by the FSM each cycle.
//  - FSM states: IDLE, DEBOUNCE, EMIT, RELEASE.
//    IDLE:     pat!=0 -> DEBOUNCE. Capture cap<=pat; this sample counts as stable sample 1.
//    DEBOUNCE: pat==0 -> IDLE (glitch, no output).
//              pat!=0 && pat!=cap -> restart: cap<=pat, count from sample 1 again.
//              pat==cap -> count. The DEB_CYCLES-th consecutive equal sample -> EMIT.
//    EMIT:     exactly 1 cycle. cap==01: pulse=1, coin=Y05. cap==10: pulse=1, coin=Y1.
//              cap==11: see CONFIGURATION. Next state is always RELEASE.
//    RELEASE:  cnt counts consecutive pat==0 samples; any pat!=0 clears cnt.
//              DEB_CYCLES consecutive zeros -> IDLE.
//  - Latency: take edge 1 as the first posedge that samples raw high, with raw held stable.
//    pulse is high in the cycle after edge SYNC_STAGES+DEB_CYCLES.
//  - One credit per insertion: a coin held indefinitely produces one pulse. The next credit
//    needs DEB_CYCLES low samples in RELEASE before the new insert starts debouncing.
//  - Counter saturates; it never wraps. Its width is CNT_W. Compares are unsigned.
//  - pulse and reject are never high together. They are never high in consecutive cycles.
// CONFIGURATION
//  COIN_REJECT_EN defined:
//    - reject port exists.
//    - cap==11 in EMIT -> reject=1 for one cycle, pulse=0, coin=NC.
//  COIN_REJECT_EN undefined:
//    - reject port is absent.
//    - cap==11 passes through EMIT silently: pulse=0, coin=NC, then RELEASE.
// STRUCTURE
//  - vend_pkg (shared with vend) holds:
//      coin_t enum {NC, Y05, Y1} and its 2-bit code values;
//      acc_state_t enum {IDLE, DEBOUNCE, EMIT, RELEASE}.
//  - Sub-module vend_sync: N-stage flop synchroniser, parameter STAGES, one instance per sensor.
//    Its flops take the same synchronous reset.
//  - FSM, counter and output registers live in coin_acceptor.
// TESTING (SYNC_STAGES=2, DEB_CYCLES=4)
//  1. Release reset with both raw lines low; wait past RELEASE. Hold coin05_raw=1 for 12 cycles.
//     -> pulse=1 and coin=01 for exactly the cycle after edge 6; coin=00 in every other cycle.
//  2. coin10_raw pattern 1,1,0,1 then held 1 for 10 cycles (bounce).
//     -> exactly one pulse with coin=10, 6 edges after the last rising sample.
//  3. coin05_raw high for 3 cycles, then low.
//     -> no pulse, coin stays 00, FSM returns to IDLE.
//  4. coin10_raw held 40 cycles -> one pulse only. Then low 2 cycles, high again -> no credit.
//     Then low 4+ cycles, high 8 cycles -> second pulse, coin=10.
//  5. Both raw lines high together for 10 cycles.
//     -> with COIN_REJECT_EN: reject=1 for one cycle at edge 6, pulse=0.
//     -> without COIN_REJECT_EN: no strobe of any kind.
//  6. Apply rst_=0 at DEBOUNCE sample 3 with coin05_raw held high through and after reset.
//     -> outputs 0 during reset; no pulse while the coin stays held.
//     -> after 4+ low cycles, a reinserted coin credits normally.
//  Drive the vend FSM from this block in a joint bench: 05 + 1 + 05 -> sell once from vend.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared coin-path types used by the coin acceptor and the vend FSM.
package vend_pkg;

  typedef enum logic [1:0] {
    NC  = 2'b00,
    Y05 = 2'b01,
    Y1  = 2'b10
  } coin_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DEBOUNCE = 2'b01,
    EMIT     = 2'b10,
    RELEASE  = 2'b11
  } acc_state_t;

  localparam logic [1:0] PAT_NONE = 2'b00;
  localparam logic [1:0] PAT_05   = 2'b01;
  localparam logic [1:0] PAT_10   = 2'b10;

endpackage

// File: rtl/vend_sync.sv
// N-stage flop synchroniser for one asynchronous sensor line.
module vend_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] q;

  always_ff @(posedge clk) begin
    if (!rst_) q <= '0;
    else       q <= {q[STAGES-2:0], din};
  end

  assign dout = q[STAGES-1];

endmodule

// File: rtl/coin_acceptor.sv
// Coin slot front end: synchronise, debounce and turn each insertion into one pulse+coin credit.
// Build option COIN_REJECT_EN adds the reject strobe for inserts seen on both channels at once.
//
// state    | meaning
// IDLE     | slot empty, waiting for a non-zero sensor pattern
// DEBOUNCE | counting consecutive identical non-zero samples
// EMIT     | one-cycle credit (or reject) strobe
// RELEASE  | waiting for DEB_CYCLES consecutive empty samples
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic  clk,
  input  logic  rst_,
  input  logic  coin05_raw,
  input  logic  coin10_raw,
  output logic  pulse,
  output coin_t coin
`ifdef COIN_REJECT_EN
  ,
  output logic  reject
`endif
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sync05;
  logic sync10;
  logic [1:0] pat;
  logic [1:0] cap;
  logic [CNT_W-1:0] cnt;
  acc_state_t state;

  vend_sync #(.STAGES(SYNC_STAGES)) u_sync05 (
    .clk  (clk),
    .rst_ (rst_),
    .din  (coin05_raw),
    .dout (sync05)
  );

  vend_sync #(.STAGES(SYNC_STAGES)) u_sync10 (
    .clk  (clk),
    .rst_ (rst_),
    .din  (coin10_raw),
    .dout (sync10)
  );

  assign pat = {sync10, sync05};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  // Strobes are set on the transition into EMIT so they coincide with the EMIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state  <= RELEASE;
      cnt    <= '0;
      cap    <= PAT_NONE;
      pulse  <= 1'b0;
      coin   <= NC;
`ifdef COIN_REJECT_EN
      reject <= 1'b0;
`endif
    end else begin
      pulse  <= 1'b0;
      coin   <= NC;
`ifdef COIN_REJECT_EN
      reject <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pat != PAT_NONE) begin
            cap   <= pat;
            cnt   <= CNT_ONE;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (pat == PAT_NONE) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (pat != cap) begin
            cap <= pat;
            cnt <= CNT_ONE;
          end else if (cnt >= CNT_LAST) begin
            cnt   <= '0;
            state <= EMIT;
            case (cap)
              PAT_05: begin
                pulse <= 1'b1;
                coin  <= Y05;
              end
              PAT_10: begin
                pulse <= 1'b1;
                coin  <= Y1;
              end
              default: begin
`ifdef COIN_REJECT_EN
                reject <= 1'b1;
`endif
              end
            endcase
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        EMIT: begin
          cnt   <= '0;
          state <= RELEASE;
        end
        RELEASE: begin
          if (pat != PAT_NONE) begin
            cnt <= '0;
          end else if (cnt >= CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          cnt   <= '0;
          state <= RELEASE;
        end
      endcase
    end
  end

endmodule
